tdm_demux_4: RTL and testbench
==============================

# tdm_demux_4

Four-channel time-division demultiplexer; receive-side counterpart of the 4:1 multiplexer used in the combinational library. It drives the slot select for a remote 4:1 mux and accepts one sample per slot. It reassembles the four slot samples into a parallel frame and presents it with a one-cycle valid strobe. Frame alignment is tracked with a sync marker.

## Interface
- W, 1, data width per channel/slot (W ≥ 1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present on in_data this cycle
- in_sync  in  1  qualifies sample as slot 0 of a frame; meaningful only with in_valid
- in_data  in  W  slot sample
- clr_err  in  1  clears sync_err
- sel  out  2  expected slot index; drives remote mux select
- out_data  out  4*W  last complete frame; channel k at [k*W +: W]
- out_valid  out  1  one-cycle pulse, new frame on out_data
- sync_err  out  1  sticky framing-error flag

## Operation
- States: HUNT, LOCKED. Slot counter 2 bits; sel = slot counter in LOCKED, 0 in HUNT.
- HUNT: samples without in_sync are dropped. in_valid & in_sync → capture slot 0, slot=1, go LOCKED.
- LOCKED, in_valid & !in_sync, slot≠0 → capture into slot register, slot++.
- LOCKED, accepted sample at slot 3 → all four slots copied to out_data together. Slot wraps to 0.
- LOCKED, in_valid & in_sync, slot=0 → normal frame start; capture slot 0, slot=1.
- LOCKED, in_valid & in_sync, slot≠0 (early sync) → partial frame discarded; sync_err set; sample captured as slot 0; slot=1.
- LOCKED, in_valid & !in_sync, slot=0 (missing sync) → sync_err set; sample dropped; go HUNT.
- in_valid low: no state change; gaps between slots are allowed.
- out_data never shows a partial frame. out_data holds until the next complete frame.
- clr_err & a new error in the same cycle → sync_err stays 1.

## Timing
- Reset values: sel=0, out_data=0, out_valid=0, sync_err=0, state HUNT, slot=0, slot registers 0.
- Latency: out_data/out_valid update on the clock edge after the edge that accepts slot 3, i.e. 1 cycle.
- Minimum frame period is 4 cycles. Back-to-back frames give out_valid every 4th cycle, with no bubble.
- sel changes on the edge that accepts a sample, so the remote mux sees the next slot index one cycle ahead.
- Reset mid-frame: the partial frame is lost and no out_valid is produced for it.

## Configuration
- TDM_DEMUX_ERR_EN defined: full checking as above.
- TDM_DEMUX_ERR_EN undefined:
  - sync_err is constant 0 and clr_err is ignored.
  - Missing sync at slot 0 is accepted as a normal frame start; no return to HUNT.
  - Early sync still resyncs and discards the partial frame.

## Structure
- Package tdm_demux_pkg holds:
  - NCH=4
  - SLOT_W=2
  - state enum {HUNT, LOCKED}
- Sub-module tdm_slot_ctr: slot counter with load-to-1, increment, wrap and clear, plus the last-slot flag.
- Top level holds the FSM, slot register bank and output frame register.

## Test plan
- Reset, then frame with W=1 sync+0, 1, 0, 1 (slots 0..3) → out_data=4'b1010, out_valid for exactly 1 cycle, sel sequence 0,1,2,3,0.
- Same frame with 2-cycle in_valid gaps between slots → identical out_data=4'b1010; sel holds during gaps.
- Three back-to-back frames 4'b1010, 4'b0101, 4'b1111 → out_valid every 4 cycles, out_data matches each frame; sync_err=0.
- Sync at slot 2 after slots 0,1 → sync_err=1, no out_valid for the aborted frame. The following frame 4'b0011 is delivered. clr_err → sync_err=0.
- With TDM_DEMUX_ERR_EN: frame start without in_sync → sync_err=1, state HUNT, samples dropped until next sync. Without the macro → frame delivered, sync_err=0.
- rst_n low after slot 2 accepted → all outputs return to reset values immediately; no out_valid; the next synced frame is delivered correctly.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared widths, FSM state and slot-counter op codes
// for the 4-channel TDM demultiplexer (optional checking: TDM_DEMUX_ERR_EN).
package tdm_demux_pkg;
   localparam int NCH    = 4;
   localparam int SLOT_W = 2;

   typedef enum logic {
      HUNT,
      LOCKED
   } state_t;

   typedef enum logic [1:0] {
      CTR_HOLD,
      CTR_CLR,
      CTR_LOAD1,
      CTR_INC
   } ctr_op_t;
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: sample input (in_valid/in_sync/in_data/clr_err) and
// frame output (sel/out_data/out_valid/sync_err); slave = demux side.
interface tdm_demux_if
   import tdm_demux_pkg::*;
#(
   parameter int W = 1
);
   logic              in_valid;
   logic              in_sync;
   logic [W-1:0]      in_data;
   logic              clr_err;
   logic [SLOT_W-1:0] sel;
   logic [NCH*W-1:0]  out_data;
   logic              out_valid;
   logic              sync_err;

   modport master (
      output in_valid, in_sync, in_data, clr_err,
      input  sel, out_data, out_valid, sync_err
   );

   modport slave (
      input  in_valid, in_sync, in_data, clr_err,
      output sel, out_data, out_valid, sync_err
   );
endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter with clear, load-to-1 and wrapping
// increment; ports clk, rst_n, op in, slot and last-slot flag out.
module tdm_slot_ctr
   import tdm_demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  ctr_op_t           op,
   output logic [SLOT_W-1:0] slot,
   output logic              last
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else begin
         unique case (op)
            CTR_CLR:   slot <= '0;
            CTR_LOAD1: slot <= SLOT_W'(1);
            CTR_INC:   slot <= slot + 1'b1;
            default:   slot <= slot;
         endcase
      end
   end

   assign last = (slot == SLOT_W'(NCH - 1));
endmodule

// File: rtl/tdm_demux_4.sv
// tdm_demux_4: reassembles 4 TDM slot samples into a parallel frame; ports
// clk, rst_n, bus (tdm_demux_if.slave). Define TDM_DEMUX_ERR_EN for checking.
module tdm_demux_4
   import tdm_demux_pkg::*;
#(
   parameter int W = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   tdm_demux_if.slave  bus
);
   state_t            state_q;
   state_t            state_d;
   ctr_op_t           ctr_op;
   logic [SLOT_W-1:0] slot;
   logic              last;
   logic              cap_en;
   logic [SLOT_W-1:0] cap_idx;
   logic              done_d;
   logic              done_q;
   logic [W-1:0]      slot_q [NCH];
   logic [NCH*W-1:0]  frame;
   logic [NCH*W-1:0]  out_data_q;
   logic              out_valid_q;
   logic              is_sync;
   logic              is_mid;
   logic              is_miss;
`ifdef TDM_DEMUX_ERR_EN
   logic              err_set;
   logic              sync_err_q;
`endif

   tdm_slot_ctr u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .op    (ctr_op),
      .slot  (slot),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= HUNT;
      else        state_q <= state_d;
   end

   assign is_sync = bus.in_sync;
   assign is_mid  = !bus.in_sync && (slot != '0);
   assign is_miss = !bus.in_sync && (slot == '0);

   always_comb begin
      state_d = state_q;
      ctr_op  = CTR_HOLD;
      cap_en  = 1'b0;
      cap_idx = slot;
      done_d  = 1'b0;
`ifdef TDM_DEMUX_ERR_EN
      err_set = 1'b0;
`endif
      if (bus.in_valid) begin
         unique case (state_q)
            HUNT: begin
               if (bus.in_sync) begin
                  cap_en  = 1'b1;
                  cap_idx = '0;
                  ctr_op  = CTR_LOAD1;
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               unique case (1'b1)
                  // Early sync drops the partial frame: its stale
                  // slots get overwritten before the next copy-out.
                  is_sync: begin
                     cap_en  = 1'b1;
                     cap_idx = '0;
                     ctr_op  = CTR_LOAD1;
`ifdef TDM_DEMUX_ERR_EN
                     err_set = (slot != '0);
`endif
                  end
                  is_mid: begin
                     cap_en = 1'b1;
                     ctr_op = CTR_INC;
                     done_d = last;
                  end
                  is_miss: begin
`ifdef TDM_DEMUX_ERR_EN
                     err_set = 1'b1;
                     ctr_op  = CTR_CLR;
                     state_d = HUNT;
`else
                     cap_en  = 1'b1;
                     cap_idx = '0;
                     ctr_op  = CTR_LOAD1;
`endif
                  end
               endcase
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) slot_q[k] <= '0;
      end else if (cap_en) begin
         slot_q[cap_idx] <= bus.in_data;
      end
   end

   always_comb begin
      frame = '0;
      for (int k = 0; k < NCH; k++) frame[k*W +: W] = slot_q[k];
   end

   // Copy-out happens one edge after slot 3 lands, so slot 3 is
   // already in the bank and a new slot 0 capture on the same edge
   // cannot corrupt the frame being published.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         done_q      <= done_d;
         out_valid_q <= done_q;
         if (done_q) out_data_q <= frame;
      end
   end

`ifdef TDM_DEMUX_ERR_EN
   // A new error wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_err_q <= 1'b0;
      else        sync_err_q <= (sync_err_q & ~bus.clr_err) | err_set;
   end

   assign bus.sync_err = sync_err_q;
`else
   assign bus.sync_err = 1'b0;
`endif

   assign bus.sel       = (state_q == LOCKED) ? slot : '0;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_tdm_demux_4.sv
// tb_tdm_demux_4: directed frames for tdm_demux_4 (W=1), scoreboard
// of expected frames checked by an out_valid monitor.
module tb_tdm_demux_4;
   localparam int W = 1;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cyc;
   logic prev_v;
   logic [4*W-1:0] exp_q [$];
   int   vt_q [$];

   tdm_demux_if #(.W(W)) bus ();

   tdm_demux_4 #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame got %0h expected none",
                     bus.out_data);
         end else begin
            logic [4*W-1:0] e;
            e = exp_q.pop_front();
            if (bus.out_data !== e) begin
               errors++;
               $display("FAIL frame got %0h expected %0h",
                        bus.out_data, e);
            end
         end
         checks++;
         if (prev_v) begin
            errors++;
            $display("FAIL pulse got 2-cycle valid expected 1");
         end
         vt_q.push_back(cyc);
      end
      prev_v <= rst_n & bus.out_valid;
   end

   task automatic put(input logic s, input logic [W-1:0] d,
                      input logic [1:0] exp_sel);
      @(negedge clk);
      chk("sel", 32'(bus.sel), 32'(exp_sel));
      bus.in_valid = 1'b1;
      bus.in_sync  = s;
      bus.in_data  = d;
   endtask

   task automatic idle(input int n, input logic [1:0] exp_sel);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_sync  = 1'b0;
         chk("sel_hold", 32'(bus.sel), 32'(exp_sel));
      end
   endtask

   task automatic send_frame(input logic [3:0] f, input int gap);
      put(1'b1, f[0], 2'd0);
      idle(gap, 2'd1);
      put(1'b0, f[1], 2'd1);
      idle(gap, 2'd2);
      put(1'b0, f[2], 2'd2);
      idle(gap, 2'd3);
      put(1'b0, f[3], 2'd3);
      exp_q.push_back(f);
   endtask

   task automatic clr();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.clr_err  = 1'b1;
      @(negedge clk);
      bus.clr_err  = 1'b0;
      chk("clr_err", 32'(bus.sync_err), 32'd0);
   endtask

   logic exp_err;
   int   n0;

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      prev_v = 1'b0;
`ifdef TDM_DEMUX_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.in_data  = '0;
      bus.clr_err  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_sel", 32'(bus.sel), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_err", 32'(bus.sync_err), 32'd0);
      rst_n = 1'b1;

      send_frame(4'b1010, 0);
      idle(3, 2'd0);

      send_frame(4'b1010, 2);
      idle(3, 2'd0);

      n0 = vt_q.size();
      send_frame(4'b1010, 0);
      send_frame(4'b0101, 0);
      send_frame(4'b1111, 0);
      idle(3, 2'd0);
      chk("b2b_count", 32'(vt_q.size() - n0), 32'd3);
      if (vt_q.size() >= n0 + 3) begin
         chk("b2b_gap1", 32'(vt_q[n0+1] - vt_q[n0]), 32'd4);
         chk("b2b_gap2", 32'(vt_q[n0+2] - vt_q[n0+1]), 32'd4);
      end
      chk("b2b_err", 32'(bus.sync_err), 32'd0);

      put(1'b1, 1'b1, 2'd0);
      put(1'b0, 1'b1, 2'd1);
      put(1'b1, 1'b1, 2'd2);
      put(1'b0, 1'b1, 2'd1);
      put(1'b0, 1'b0, 2'd2);
      put(1'b0, 1'b0, 2'd3);
      exp_q.push_back(4'b0011);
      idle(3, 2'd0);
      chk("early_err", 32'(bus.sync_err), 32'(exp_err));
      clr();

`ifdef TDM_DEMUX_ERR_EN
      put(1'b0, 1'b1, 2'd0);
      put(1'b0, 1'b0, 2'd0);
      put(1'b0, 1'b1, 2'd0);
      idle(1, 2'd0);
      chk("miss_err", 32'(bus.sync_err), 32'd1);
      clr();
      send_frame(4'b0110, 0);
      idle(3, 2'd0);
`else
      put(1'b0, 1'b1, 2'd0);
      put(1'b0, 1'b0, 2'd1);
      put(1'b0, 1'b1, 2'd2);
      put(1'b0, 1'b1, 2'd3);
      exp_q.push_back(4'b1101);
      idle(3, 2'd0);
      chk("miss_err", 32'(bus.sync_err), 32'd0);
`endif

      put(1'b1, 1'b1, 2'd0);
      put(1'b0, 1'b1, 2'd1);
      put(1'b0, 1'b1, 2'd2);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sel", 32'(bus.sel), 32'd0);
      chk("mid_rst_data", 32'(bus.out_data), 32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_err", 32'(bus.sync_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2, 2'd0);
      send_frame(4'b1001, 0);
      idle(4, 2'd0);

      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
